// File: rtl/ps2_rx_fifo.sv
// ps2_rx_fifo: filtered PS/2 device-to-host receiver feeding a first-word-fall-through byte FIFO.
module ps2_rx_fifo #(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 100000,
  parameter int FIFO_DEPTH  = 16,
  parameter bit PARITY_EN   = 1'b1
) (
  input  logic                            clk,
  input  logic                            Locked,
  input  logic                            ps2_clk,
  input  logic                            ps2_data,
  output logic [7:0]                      rx_data,
  output logic                            rx_valid,
  input  logic                            rx_ready,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count,
  output logic                            parity_err,
  output logic                            frame_err,
  output logic                            overflow,
  output logic [1:0]                      state
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [7:0] FL_MAX = 8'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT_CYC - 1);
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
  state_t st;
  logic [1:0] rsync, s1, s2, filt;
  logic [7:0] fcnt [2];
  logic rst_n, clk_q, strobe, bit_in, push, wr, pop, full;
  logic [2:0] bit_cnt;
  logic [7:0] shreg;
  logic par;
  logic [TW-1:0] to_cnt;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [7:0] mem [FIFO_DEPTH];
  // reset asserts immediately but leaves reset only after two clean clk edges
  always_ff @(posedge clk or negedge Locked)
    if (!Locked) rsync <= 2'b00;
    else rsync <= {rsync[0], 1'b1};
  assign rst_n = rsync[1];
  // bit 0 = ps2_clk, bit 1 = ps2_data
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s1 <= 2'b11;
      s2 <= 2'b11;
      filt <= 2'b11;
      fcnt[0] <= '0;
      fcnt[1] <= '0;
      clk_q <= 1'b1;
    end else begin
      s1 <= {ps2_data, ps2_clk};
      s2 <= s1;
      clk_q <= filt[0];
      for (int k = 0; k < 2; k++)
        if (s2[k] == filt[k]) fcnt[k] <= '0;
        else if (fcnt[k] == FL_MAX) begin
          filt[k] <= s2[k];
          fcnt[k] <= '0;
        end else fcnt[k] <= fcnt[k] + 8'd1;
    end
  assign strobe = clk_q & ~filt[0];
  assign bit_in = filt[1];
  assign state = st;
  assign push = strobe && st == STOP && bit_in && (!PARITY_EN || ^{shreg, par});
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      st <= IDLE;
      bit_cnt <= '0;
      shreg <= '0;
      par <= 1'b0;
      to_cnt <= '0;
      parity_err <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      parity_err <= 1'b0;
      frame_err <= 1'b0;
      to_cnt <= (strobe || st == IDLE) ? '0 : to_cnt + 1'b1;
      if (strobe)
        case (st)
          IDLE: if (!bit_in) begin
            st <= DATA;
            bit_cnt <= '0;
          end
          DATA: begin
            shreg <= {bit_in, shreg[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) st <= PARITY;
          end
          PARITY: begin
            par <= bit_in;
            st <= STOP;
          end
          STOP: begin
            st <= IDLE;
            frame_err <= !bit_in;
            parity_err <= bit_in && PARITY_EN && !(^{shreg, par});
          end
        endcase
      else if (st != IDLE && to_cnt == TO_MAX) begin
        st <= IDLE;
        frame_err <= 1'b1;
      end
    end
  assign full = fifo_count == CW'(FIFO_DEPTH);
  assign rx_valid = fifo_count != '0;
  assign pop = rx_valid & rx_ready;
  assign wr = push & (!full | pop);
  assign rx_data = rx_valid ? mem[rd_ptr] : 8'h00;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fifo_count <= '0;
      overflow <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr + AW'(wr);
      rd_ptr <= rd_ptr + AW'(pop);
      fifo_count <= fifo_count + CW'(wr) - CW'(pop);
      overflow <= push & full & !pop;
    end
  always_ff @(posedge clk)
    if (wr) mem[wr_ptr] <= shreg;
endmodule

// File: tb/tb_ps2_rx_fifo.sv
// tb_ps2_rx_fifo: directed PS/2 frames against a parity-checking and a parity-ignoring instance.
module tb_ps2_rx_fifo;
  localparam int TO = 1000;
  localparam int HALF = 20;
  logic clk = 1'b0;
  logic Locked = 1'b0;
  logic ps2_clk = 1'b1;
  logic ps2_data = 1'b1;
  logic rx_ready = 1'b0;
  logic rdy1 = 1'b1;
  logic [7:0] d0, d1;
  logic v0, v1, pe0, pe1, fe0, fe1, ov0, ov1;
  logic [4:0] c0, c1;
  logic [1:0] st0, st1;
  int checks = 0;
  int errors = 0;
  int n_pe = 0, n_fe = 0, n_ov = 0, pops1 = 0;
  logic [7:0] last1 = 8'h00;
  int b_pe, b_fe, b_ov, b_pops;
  always #5 clk = ~clk;
  ps2_rx_fifo #(.TIMEOUT_CYC(TO)) u0 (
    .clk(clk), .Locked(Locked), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .rx_data(d0), .rx_valid(v0), .rx_ready(rx_ready), .fifo_count(c0),
    .parity_err(pe0), .frame_err(fe0), .overflow(ov0), .state(st0));
  ps2_rx_fifo #(.TIMEOUT_CYC(TO), .PARITY_EN(1'b0)) u1 (
    .clk(clk), .Locked(Locked), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .rx_data(d1), .rx_valid(v1), .rx_ready(rdy1), .fifo_count(c1),
    .parity_err(pe1), .frame_err(fe1), .overflow(ov1), .state(st1));
  always @(posedge clk) begin
    if (pe0) n_pe <= n_pe + 1;
    if (fe0) n_fe <= n_fe + 1;
    if (ov0) n_ov <= n_ov + 1;
    if (v1) begin
      last1 <= d1;
      pops1 <= pops1 + 1;
    end
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic odd_par(input logic [7:0] d);
    return ~^d;
  endfunction
  task automatic send(input logic [7:0] d, input logic p, input logic s, input int nbits = 11,
                      input bit glitch = 1'b0);
    logic [10:0] bits;
    bits = {s, p, d, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_data = bits[i];
      if (glitch) begin
        repeat (6) @(posedge clk);
        ps2_clk = 1'b0;
        repeat (3) @(posedge clk);
        ps2_clk = 1'b1;
        repeat (HALF - 9) @(posedge clk);
      end else repeat (HALF) @(posedge clk);
      ps2_clk = 1'b0;
      repeat (HALF) @(posedge clk);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    repeat (30) @(posedge clk);
    @(negedge clk);
  endtask
  task automatic pop_one();
    @(negedge clk);
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
  endtask
  task automatic snap();
    b_pe = n_pe;
    b_fe = n_fe;
    b_ov = n_ov;
    b_pops = pops1;
  endtask
  initial begin
    repeat (5) @(negedge clk);
    check("rst_state", 32'(st0), 0);
    check("rst_count", 32'(c0), 0);
    check("rst_valid", 32'(v0), 0);
    check("rst_data", 32'(d0), 0);
    Locked = 1'b1;
    repeat (10) @(negedge clk);
    snap();
    send(8'hA5, 1'b1, 1'b1);
    check("a5_data", 32'(d0), 32'hA5);
    check("a5_valid", 32'(v0), 1);
    check("a5_count", 32'(c0), 1);
    check("a5_perr", 32'(n_pe - b_pe), 0);
    check("a5_ferr", 32'(n_fe - b_fe), 0);
    pop_one();
    check("a5_popped", 32'(c0), 0);
    snap();
    send(8'h07, 1'b1, 1'b1);
    check("par_perr", 32'(n_pe - b_pe), 1);
    check("par_count", 32'(c0), 0);
    check("nopar_pops", 32'(pops1 - b_pops), 1);
    check("nopar_data", 32'(last1), 32'h07);
    snap();
    send(8'h00, 1'b1, 1'b0);
    check("stop_ferr", 32'(n_fe - b_fe), 1);
    check("stop_perr", 32'(n_pe - b_pe), 0);
    check("stop_count", 32'(c0), 0);
    check("stop_state", 32'(st0), 0);
    snap();
    send(8'hFF, 1'b1, 1'b1, 5);
    check("to_midframe", 32'(st0), 1);
    repeat (TO + 50) @(negedge clk);
    check("to_ferr", 32'(n_fe - b_fe), 1);
    check("to_state", 32'(st0), 0);
    check("to_count", 32'(c0), 0);
    send(8'h3C, 1'b1, 1'b1);
    check("3c_data", 32'(d0), 32'h3C);
    check("3c_count", 32'(c0), 1);
    pop_one();
    snap();
    for (int i = 1; i <= 17; i++) send(8'(i), odd_par(8'(i)), 1'b1);
    check("ovf_count", 32'(c0), 16);
    check("ovf_pulses", 32'(n_ov - b_ov), 1);
    check("ovf_errs", 32'(n_pe - b_pe + n_fe - b_fe), 0);
    rx_ready = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      check($sformatf("pop_%0d", i), 32'(d0), 32'(i));
      @(negedge clk);
    end
    rx_ready = 1'b0;
    check("drained", 32'(c0), 0);
    check("drained_valid", 32'(v0), 0);
    snap();
    send(8'h5A, 1'b1, 1'b1, 11, 1'b1);
    check("glitch_data", 32'(d0), 32'h5A);
    check("glitch_count", 32'(c0), 1);
    check("glitch_errs", 32'(n_pe - b_pe + n_fe - b_fe), 0);
    pop_one();
    send(8'h81, 1'b1, 1'b1);
    check("pre_rst_count", 32'(c0), 1);
    send(8'h55, 1'b0, 1'b1, 4);
    snap();
    Locked = 1'b0;
    #1;
    check("mid_rst_state", 32'(st0), 0);
    check("mid_rst_count", 32'(c0), 0);
    check("mid_rst_valid", 32'(v0), 0);
    check("mid_rst_data", 32'(d0), 0);
    repeat (5) @(negedge clk);
    Locked = 1'b1;
    repeat (TO + 50) @(negedge clk);
    check("rst_no_pulse", 32'(n_pe - b_pe + n_fe - b_fe), 0);
    send(8'hC3, 1'b1, 1'b1);
    check("c3_data", 32'(d0), 32'hC3);
    check("c3_count", 32'(c0), 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ps2_rx_fifo.md
PS2_RX_FIFO -- requirements
Module: ps2_rx_fifo

Interface
REQ-001 FILTER_LEN, 8, consecutive identical clk samples required before a filtered PS/2 line level changes (range 1..255).
REQ-002 TIMEOUT_CYC, 100000, clk cycles with no PS/2 clock falling edge before an in-progress frame is aborted (minimum 16).
REQ-003 FIFO_DEPTH, 16, receive FIFO entries (power of two, minimum 2).
REQ-004 PARITY_EN, 1, 1 = odd-parity check enforced; 0 = parity bit captured but ignored.
REQ-005 clk  input  1  system clock; all logic on its rising edge.
REQ-006 Locked  input  1  asynchronous active-low reset (0 = reset asserted).
REQ-007 ps2_clk  input  1  raw PS/2 clock line, asynchronous to clk.
REQ-008 ps2_data  input  1  raw PS/2 data line, asynchronous to clk.
REQ-009 rx_data  output  8  FIFO head byte, valid while rx_valid = 1.
REQ-010 rx_valid  output  1  FIFO not empty.
REQ-011 rx_ready  input  1  consumer accepts head byte when high with rx_valid.
REQ-012 fifo_count  output  $clog2(FIFO_DEPTH+1)  current FIFO occupancy.
REQ-013 parity_err  output  1  one-cycle pulse: frame discarded for parity failure.
REQ-014 frame_err  output  1  one-cycle pulse: frame discarded for bad stop bit or timeout.
REQ-015 overflow  output  1  one-cycle pulse: good frame dropped because FIFO full.
REQ-016 state  output  2  FSM state encoding, for debug.

Function
REQ-017 Each PS/2 line SHALL pass a 2-flop synchroniser and then a saturating stability filter; the filtered level updates only after FILTER_LEN consecutive equal synchronised samples.
REQ-018 A sample strobe SHALL be generated for exactly one clk cycle on each 1->0 transition of filtered ps2_clk; filtered ps2_data in that cycle is the sampled bit.
REQ-019 FSM states SHALL be IDLE=0, DATA=1, PARITY=2, STOP=3.
REQ-020 IDLE: strobe with bit 0 -> DATA, bit counter cleared; strobe with bit 1 ignored, remain IDLE.
REQ-021 DATA: each strobe shifts the bit in LSB-first; after the 8th data bit -> PARITY.
REQ-022 PARITY: strobe captures parity bit -> STOP.
REQ-023 STOP: on strobe the FSM returns to IDLE; stop bit 0 -> frame_err pulse, discard; else if PARITY_EN and XOR(8 data bits, parity) = 0 -> parity_err pulse, discard; else byte is pushed.
REQ-024 Stop-bit error SHALL take precedence over parity error; only one error pulse per frame.
REQ-025 Timeout counter SHALL clear on every strobe and in IDLE; reaching TIMEOUT_CYC outside IDLE -> frame_err pulse, partial frame discarded, IDLE next cycle.
REQ-026 Error and overflow pulses SHALL assert in the clk cycle after the deciding strobe (or timeout).
REQ-027 FIFO is first-word-fall-through: an accepted byte SHALL appear on rx_data with rx_valid = 1 in the cycle after the stop-bit strobe when the FIFO was empty.
REQ-028 Pop occurs on a clk edge where rx_valid and rx_ready are both 1; rx_ready while empty has no effect.
REQ-029 Push while full with no simultaneous pop: byte dropped, overflow pulses, FIFO contents unchanged.
REQ-030 Push and pop in the same cycle while full: both performed, no overflow, fifo_count unchanged.
REQ-031 Push and pop in the same cycle at any occupancy: fifo_count unchanged; pointers wrap modulo FIFO_DEPTH.
REQ-032 fifo_count SHALL never exceed FIFO_DEPTH nor underflow below 0.

Reset
REQ-033 Locked = 0 SHALL immediately (asynchronously) force: state IDLE, FIFO empty (fifo_count 0, rx_valid 0), rx_data 0x00, all pulses 0, counters 0, filtered line levels 1, synchroniser flops 1.
REQ-034 Reset asserted mid-frame SHALL discard the partial frame with no error pulse; after release the next start bit is received normally.
REQ-035 Reset release SHALL be synchronised to clk internally (2-flop deassertion).

Verification
REQ-036 Frame 0xA5, parity 1, stop 1 -> rx_data 0xA5, rx_valid 1, fifo_count 1, no error pulses.
REQ-037 Frame 0x07 with parity 1 (wrong), PARITY_EN=1 -> parity_err one pulse, fifo_count stays 0; repeat with PARITY_EN=0 -> 0x07 pushed.
REQ-038 Frame 0x00 with stop bit 0 -> frame_err one pulse, nothing pushed, state returns to 0.
REQ-039 Start bit + 4 data bits then ps2_clk held high for TIMEOUT_CYC cycles -> frame_err pulse, state 0; following complete frame 0x3C received correctly.
REQ-040 rx_ready = 0, send FIFO_DEPTH+1 valid frames (0x01..0x11 at depth 16) -> fifo_count 16, one overflow pulse, pop order 0x01..0x10.
REQ-041 Glitches on ps2_clk shorter than FILTER_LEN cycles during frame 0x5A -> no extra strobes, 0x5A received.
